// File: rtl/vision_pkg.sv
// vision_pkg
//   Shared constants and types for the green-object tracking path.
//   H_ACT/V_ACT  : active frame geometry (pixels per line, lines per frame)
//   MIN_PIXELS   : smallest detected-pixel count treated as a real object
//   COORD_W      : coordinate width
//   CNT_W        : pixel-count width (holds H_ACT*V_ACT)
//   SUM_W        : coordinate-sum width (holds H_ACT*V_ACT*(H_ACT-1))
//   state_t      : tracker FSM states
package vision_pkg;

    localparam int H_ACT      = 320;
    localparam int V_ACT      = 240;
    localparam int MIN_PIXELS = 64;
    localparam int COORD_W    = 10;
    localparam int CNT_W      = 17;
    localparam int SUM_W      = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider
//   Restoring unsigned bit-serial divider with a fixed SUM_W-cycle run.
//   Ports:
//     clk, reset_n  : clock, synchronous active-low reset
//     start         : one-cycle request; dividend/divisor are sampled with it
//     dividend      : SUM_W-bit unsigned dividend
//     divisor       : CNT_W-bit unsigned divisor
//     quotient      : low OUT_W bits of the quotient, valid while done is high
//                     and held until the next start
//     done          : one-cycle pulse when the quotient is final
//   Handshake: start is accepted unconditionally (it restarts any run in
//   flight); done rises SUM_W-1 cycles after the start cycle, so the quotient
//   is usable in the cycle directly following the SUM_W-th clock edge of the
//   run. A zero divisor yields an all-ones quotient and is not flagged.
module seq_divider #(
    parameter int SUM_W = vision_pkg::SUM_W,
    parameter int CNT_W = vision_pkg::CNT_W,
    parameter int OUT_W = vision_pkg::COORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [OUT_W-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(SUM_W + 1);

    logic [CNT_W-1:0] rem_q;
    logic [SUM_W-1:0] quot_q;
    logic [CNT_W-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [CNT_W-1:0] src_rem;
    logic [SUM_W-1:0] src_quot;
    logic [CNT_W-1:0] src_dvs;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] rem_n;
    logic [SUM_W-1:0] quot_n;
    logic             q_bit;

    // The first iteration is taken directly from the inputs in the start
    // cycle, so SUM_W edges (start edge included) produce the full quotient.
    always_comb begin
        src_rem  = start ? '0       : rem_q;
        src_quot = start ? dividend : quot_q;
        src_dvs  = start ? divisor  : dvs_q;
        trial    = {src_rem, src_quot[SUM_W-1]};
        q_bit    = 1'b0;
        rem_n    = trial[CNT_W-1:0];
        if (trial >= {1'b0, src_dvs}) begin
            q_bit = 1'b1;
            rem_n = CNT_W'(trial - {1'b0, src_dvs});
        end
        quot_n = {src_quot[SUM_W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= rem_n;
                quot_q <= quot_n;
                dvs_q  <= divisor;
                cnt_q  <= CW'(SUM_W - 1);
                done   <= (SUM_W == 1);
            end else if (cnt_q != '0) begin
                rem_q  <= rem_n;
                quot_q <= quot_n;
                cnt_q  <= cnt_q - CW'(1);
                done   <= (cnt_q == CW'(1));
            end
        end
    end

    assign quotient = quot_q[OUT_W-1:0];

endmodule

// File: rtl/green_blob_tracker.sv
// green_blob_tracker
//   Reduces each frame of green-classified pixels to one object: pixel count,
//   bounding box and floor-of-mean centroid, published once per frame.
//   Ports:
//     clk, reset_n           : pixel clock, synchronous active-low reset
//     de                     : active-video qualifier (pixels ignored when low)
//     x_pixel, y_pixel       : coordinates of the current pixel
//     g_detect               : green flag for the current pixel
//     result_valid           : one-cycle pulse when the outputs update
//     found                  : last frame had at least MIN_PIXELS detections
//     pix_count              : detected pixels in the last frame
//     cx, cy                 : centroid (held when found=0)
//     x_min..y_max           : bounding box (held when found=0)
//     overrun                : one-cycle pulse when a frame end is dropped
//     state_dbg              : current FSM state (vision_pkg::state_t encoding)
//   Latency: result_valid rises 2*SUM_W+1 edges after the frame-end pixel.
module green_blob_tracker #(
    parameter int H_ACT      = vision_pkg::H_ACT,
    parameter int V_ACT      = vision_pkg::V_ACT,
    parameter int MIN_PIXELS = vision_pkg::MIN_PIXELS,
    parameter int COORD_W    = vision_pkg::COORD_W,
    parameter int CNT_W      = vision_pkg::CNT_W,
    parameter int SUM_W      = vision_pkg::SUM_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               de,
    input  logic [COORD_W-1:0] x_pixel,
    input  logic [COORD_W-1:0] y_pixel,
    input  logic               g_detect,
    output logic               result_valid,
    output logic               found,
    output logic [CNT_W-1:0]   pix_count,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic               overrun,
    output logic [1:0]         state_dbg
);

    import vision_pkg::*;

    state_t state, state_n;

    logic pix_hit;
    logic frame_end;

    assign pix_hit   = de & g_detect;
    assign frame_end = de && (x_pixel == COORD_W'(H_ACT - 1))
                          && (y_pixel == COORD_W'(V_ACT - 1));

    // Running accumulators for the frame currently being received.
    logic [CNT_W-1:0]   acc_count;
    logic [SUM_W-1:0]   acc_sx, acc_sy;
    logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

    // Accumulator values including the current pixel; the frame-end pixel is
    // snapshotted from these so it counts towards its own frame.
    logic [CNT_W-1:0]   cur_count;
    logic [SUM_W-1:0]   cur_sx, cur_sy;
    logic [COORD_W-1:0] cur_xmin, cur_xmax, cur_ymin, cur_ymax;

    always_comb begin
        cur_count = acc_count;
        cur_sx    = acc_sx;
        cur_sy    = acc_sy;
        cur_xmin  = acc_xmin;
        cur_xmax  = acc_xmax;
        cur_ymin  = acc_ymin;
        cur_ymax  = acc_ymax;
        if (pix_hit) begin
            cur_count = acc_count + CNT_W'(1);
            cur_sx    = acc_sx + SUM_W'(x_pixel);
            cur_sy    = acc_sy + SUM_W'(y_pixel);
            if (x_pixel < acc_xmin) cur_xmin = x_pixel;
            if (x_pixel > acc_xmax) cur_xmax = x_pixel;
            if (y_pixel < acc_ymin) cur_ymin = y_pixel;
            if (y_pixel > acc_ymax) cur_ymax = y_pixel;
        end
    end

    // Cleared on every frame end, whether or not the frame is accepted, so
    // the next frame accumulates while the previous one is being divided.
    always_ff @(posedge clk) begin
        if (!reset_n || frame_end) begin
            acc_count <= '0;
            acc_sx    <= '0;
            acc_sy    <= '0;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
        end else if (pix_hit) begin
            acc_count <= cur_count;
            acc_sx    <= cur_sx;
            acc_sy    <= cur_sy;
            acc_xmin  <= cur_xmin;
            acc_xmax  <= cur_xmax;
            acc_ymin  <= cur_ymin;
            acc_ymax  <= cur_ymax;
        end
    end

    // Divider sharing: x is started straight from the live sums at frame end,
    // y from the snapshot as soon as x completes.
    logic               div_start;
    logic [SUM_W-1:0]   div_dividend;
    logic [CNT_W-1:0]   div_divisor;
    logic [COORD_W-1:0] div_quot;
    logic               div_done;

    logic               snap_load;
    logic               qx_load;
    logic               publish;

    logic [CNT_W-1:0]   snap_count;
    logic [SUM_W-1:0]   snap_sy;
    logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
    logic [COORD_W-1:0] qx;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n      = state;
        div_start    = 1'b0;
        div_dividend = snap_sy;
        div_divisor  = snap_count;
        snap_load    = 1'b0;
        qx_load      = 1'b0;
        publish      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    snap_load    = 1'b1;
                    div_start    = 1'b1;
                    div_dividend = cur_sx;
                    div_divisor  = cur_count;
                    state_n      = DIV_X;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    qx_load   = 1'b1;
                    div_start = 1'b1;
                    state_n   = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_done) state_n = PUBLISH;
            end
            PUBLISH: begin
                publish = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign state_dbg = state;

    seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W),
        .OUT_W (COORD_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_count <= '0;
            snap_sy    <= '0;
            snap_xmin  <= '0;
            snap_xmax  <= '0;
            snap_ymin  <= '0;
            snap_ymax  <= '0;
            qx         <= '0;
        end else begin
            if (snap_load) begin
                snap_count <= cur_count;
                snap_sy    <= cur_sy;
                snap_xmin  <= cur_xmin;
                snap_xmax  <= cur_xmax;
                snap_ymin  <= cur_ymin;
                snap_ymax  <= cur_ymax;
            end
            if (qx_load) qx <= div_quot;
        end
    end

    // In PUBLISH the divider still holds the y quotient.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            found        <= 1'b0;
            pix_count    <= '0;
            cx           <= '0;
            cy           <= '0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
        end else begin
            result_valid <= publish;
            overrun      <= frame_end && (state != IDLE);
            if (publish) begin
                pix_count <= snap_count;
                found     <= (snap_count >= CNT_W'(MIN_PIXELS));
                if (snap_count >= CNT_W'(MIN_PIXELS)) begin
                    cx    <= qx;
                    cy    <= div_quot;
                    x_min <= snap_xmin;
                    x_max <= snap_xmax;
                    y_min <= snap_ymin;
                    y_max <= snap_ymax;
                end
            end
        end
    end

endmodule

// File: tb/tb_green_blob_tracker.sv
module tb_green_blob_tracker;

    import vision_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                de = 1'b0;
    logic [COORD_W-1:0]  x_pixel = '0;
    logic [COORD_W-1:0]  y_pixel = '0;
    logic                g_detect = 1'b0;
    logic                result_valid;
    logic                found;
    logic [CNT_W-1:0]    pix_count;
    logic [COORD_W-1:0]  cx, cy, x_min, x_max, y_min, y_max;
    logic                overrun;
    logic [1:0]          state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    green_blob_tracker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .de           (de),
        .x_pixel      (x_pixel),
        .y_pixel      (y_pixel),
        .g_detect     (g_detect),
        .result_valid (result_valid),
        .found        (found),
        .pix_count    (pix_count),
        .cx           (cx),
        .cy           (cy),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_min        (y_min),
        .y_max        (y_max),
        .overrun      (overrun),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks: inputs change on the falling edge, DUT samples on rising
    task automatic drive_pixel(input int x, input int y, input logic g);
        @(negedge clk);
        de       = 1'b1;
        x_pixel  = COORD_W'(x);
        y_pixel  = COORD_W'(y);
        g_detect = g;
    endtask

    task automatic blank_pixel(input int x, input int y);
        @(negedge clk);
        de       = 1'b0;
        x_pixel  = COORD_W'(x);
        y_pixel  = COORD_W'(y);
        g_detect = 1'b1;
    endtask

    task automatic send_block(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                drive_pixel(x, y, 1'b1);
    endtask

    task automatic end_frame(input logic g);
        drive_pixel(H_ACT - 1, V_ACT - 1, g);
    endtask

    // n counts rising edges after the frame-end edge; -1 means timeout
    task automatic wait_result(output int lat);
        lat = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            de       = 1'b0;
            g_detect = 1'b0;
            if (result_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({result_valid, overrun, found} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {result_valid, overrun, found}); end
        n_cmp++; if (pix_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", pix_count); end
        n_cmp++; if ({cx, cy} !== '0) begin n_bad++; $display("FAIL reset_centroid: got %0d,%0d want 0,0", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== '0) begin n_bad++; $display("FAIL reset_bbox: got %0d %0d %0d %0d want 0 0 0 0", x_min, x_max, y_min, y_max); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square();
        int lat;
        send_block(100, 109, 50, 59);
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL square_latency: got %0d want 51", lat); end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL square_found: got %b want 1", found); end
        n_cmp++; if (pix_count !== 17'd100) begin n_bad++; $display("FAIL square_count: got %0d want 100", pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd104, 10'd54}) begin n_bad++; $display("FAIL square_centroid: got %0d,%0d want 104,54", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== {10'd100, 10'd109, 10'd50, 10'd59}) begin n_bad++; $display("FAIL square_bbox: got %0d %0d %0d %0d want 100 109 50 59", x_min, x_max, y_min, y_max); end
        @(negedge clk);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL square_pulse_width: got %b want 0", result_valid); end
    endtask

    task automatic test_below_min();
        int lat;
        send_block(200, 208, 10, 16);
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL small_latency: got %0d want 51", lat); end
        n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL small_found: got %b want 0", found); end
        n_cmp++; if (pix_count !== 17'd63) begin n_bad++; $display("FAIL small_count: got %0d want 63", pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd104, 10'd54}) begin n_bad++; $display("FAIL small_centroid_hold: got %0d,%0d want 104,54", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== {10'd100, 10'd109, 10'd50, 10'd59}) begin n_bad++; $display("FAIL small_bbox_hold: got %0d %0d %0d %0d want 100 109 50 59", x_min, x_max, y_min, y_max); end
    endtask

    task automatic test_empty();
        int lat;
        int extra;
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL empty_latency: got %0d want 51", lat); end
        n_cmp++; if ({found, pix_count} !== {1'b0, 17'd0}) begin n_bad++; $display("FAIL empty_result: got found=%b count=%0d want 0 0", found, pix_count); end
        n_cmp++; if ($isunknown({found, pix_count, cx, cy, x_min, x_max, y_min, y_max}) !== 1'b0) begin n_bad++; $display("FAIL empty_no_x: got unknown bits want none"); end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL empty_single_pulse: got %0d extra pulses want 0", extra); end
    endtask

    task automatic test_blanking();
        int lat;
        blank_pixel(5, 5);
        blank_pixel(150, 100);
        blank_pixel(H_ACT - 1, V_ACT - 1);
        blank_pixel(0, 0);
        drive_pixel(0, 0, 1'b1);
        blank_pixel(1, 0);
        blank_pixel(300, 200);
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL blank_latency: got %0d want 51", lat); end
        n_cmp++; if ({found, pix_count} !== {1'b0, 17'd1}) begin n_bad++; $display("FAIL blank_count: got found=%b count=%0d want 0 1", found, pix_count); end
    endtask

    task automatic test_min_boundary();
        int lat;
        send_block(312, 319, 232, 238);
        send_block(312, 318, 239, 239);
        end_frame(1'b1);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL edge_latency: got %0d want 51", lat); end
        n_cmp++; if ({found, pix_count} !== {1'b1, 17'd64}) begin n_bad++; $display("FAIL edge_count: got found=%b count=%0d want 1 64", found, pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd315, 10'd235}) begin n_bad++; $display("FAIL edge_centroid: got %0d,%0d want 315,235", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== {10'd312, 10'd319, 10'd232, 10'd239}) begin n_bad++; $display("FAIL edge_bbox: got %0d %0d %0d %0d want 312 319 232 239", x_min, x_max, y_min, y_max); end
    endtask

    task automatic test_overrun();
        int lat;
        int ov_cnt, ov_n, rv_cnt, rv_n;
        ov_cnt = 0; ov_n = -1; rv_cnt = 0; rv_n = -1;
        send_block(10, 19, 20, 29);
        end_frame(1'b0);
        for (int n = 0; n < 130; n++) begin
            @(negedge clk);
            de = 1'b0;
            g_detect = 1'b0;
            if (overrun === 1'b1) begin ov_cnt++; ov_n = n; end
            if (result_valid === 1'b1) begin rv_cnt++; rv_n = n; end
            if (n >= 5 && n <= 9) begin
                de = 1'b1; g_detect = 1'b1;
                x_pixel = COORD_W'(50 + n); y_pixel = COORD_W'(5);
            end
            if (n == 19) begin
                de = 1'b1; g_detect = 1'b0;
                x_pixel = COORD_W'(H_ACT - 1); y_pixel = COORD_W'(V_ACT - 1);
            end
        end
        n_cmp++; if ({ov_cnt, ov_n} !== {32'd1, 32'd20}) begin n_bad++; $display("FAIL ovr_pulse: got %0d pulses at %0d want 1 at 20", ov_cnt, ov_n); end
        n_cmp++; if ({rv_cnt, rv_n} !== {32'd1, 32'd51}) begin n_bad++; $display("FAIL ovr_results: got %0d results at %0d want 1 at 51", rv_cnt, rv_n); end
        n_cmp++; if ({found, pix_count} !== {1'b1, 17'd100}) begin n_bad++; $display("FAIL ovr_count: got found=%b count=%0d want 1 100", found, pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd14, 10'd24}) begin n_bad++; $display("FAIL ovr_centroid: got %0d,%0d want 14,24", cx, cy); end
        send_block(40, 47, 60, 67);
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if ({found, pix_count} !== {1'b1, 17'd64}) begin n_bad++; $display("FAIL post_ovr_count: got found=%b count=%0d want 1 64", found, pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd43, 10'd63}) begin n_bad++; $display("FAIL post_ovr_centroid: got %0d,%0d want 43,63", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== {10'd40, 10'd47, 10'd60, 10'd67}) begin n_bad++; $display("FAIL post_ovr_bbox: got %0d %0d %0d %0d want 40 47 60 67", x_min, x_max, y_min, y_max); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int rv_cnt;
        rv_cnt = 0;
        send_block(100, 109, 50, 59);
        end_frame(1'b0);
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            de = 1'b0;
            g_detect = 1'b0;
            if (result_valid === 1'b1) rv_cnt++;
            if (n == 9) reset_n = 1'b0;
            if (n == 10) begin
                reset_n = 1'b1;
                n_cmp++; if ({found, pix_count, cx, cy} !== '0) begin n_bad++; $display("FAIL midrst_outputs: got found=%b count=%0d c=%0d,%0d want zeros", found, pix_count, cx, cy); end
                n_cmp++; if ({x_min, x_max, y_min, y_max} !== '0) begin n_bad++; $display("FAIL midrst_bbox: got %0d %0d %0d %0d want 0 0 0 0", x_min, x_max, y_min, y_max); end
                n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", state_dbg); end
            end
        end
        n_cmp++; if (rv_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_result: got %0d pulses want 0", rv_cnt); end
        send_block(0, 11, 0, 7);
        end_frame(1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 51) begin n_bad++; $display("FAIL after_rst_latency: got %0d want 51", lat); end
        n_cmp++; if ({found, pix_count} !== {1'b1, 17'd96}) begin n_bad++; $display("FAIL after_rst_count: got found=%b count=%0d want 1 96", found, pix_count); end
        n_cmp++; if ({cx, cy} !== {10'd5, 10'd3}) begin n_bad++; $display("FAIL after_rst_centroid: got %0d,%0d want 5,3", cx, cy); end
        n_cmp++; if ({x_min, x_max, y_min, y_max} !== {10'd0, 10'd11, 10'd0, 10'd7}) begin n_bad++; $display("FAIL after_rst_bbox: got %0d %0d %0d %0d want 0 11 0 7", x_min, x_max, y_min, y_max); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_below_min();
        test_empty();
        test_blanking();
        test_min_boundary();
        test_overrun();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/green_blob_tracker.md
# green_blob_tracker

Consumes the per-pixel green-classification flag produced by the colour-detect stage and reduces each frame to one tracked object: pixel count, bounding box and integer centroid. It sits between the detect stage and the game logic / overlay renderer and publishes one result per frame during vertical blanking. Division for the centroid is done by a shared bit-serial divider, so the result arrives a fixed number of cycles after the last active pixel.

## Interface

- H_ACT, 320, active pixels per line
- V_ACT, 240, active lines per frame
- MIN_PIXELS, 64, minimum detected-pixel count for a valid object
- COORD_W, 10, coordinate width
- CNT_W, 17, pixel-count width (holds H_ACT*V_ACT)
- SUM_W, 25, coordinate-sum width (holds H_ACT*V_ACT*(H_ACT-1))

- clk  in  1  pixel clock
- reset_n  in  1  synchronous reset, active-low
- de  in  1  active-video qualifier; pixel inputs are ignored when low
- x_pixel  in  COORD_W  column of current pixel
- y_pixel  in  COORD_W  row of current pixel
- g_detect  in  1  green-classification flag for current pixel
- result_valid  out  1  one-cycle pulse when outputs update
- found  out  1  1 = last frame had count >= MIN_PIXELS
- pix_count  out  CNT_W  detected pixels in last frame
- cx, cy  out  COORD_W  centroid (floor of mean)
- x_min, x_max, y_min, y_max  out  COORD_W  bounding box
- overrun  out  1  one-cycle pulse when a frame end is dropped

## Operation

- Accumulation (all states): on de=1 and g_detect=1: count+=1, sum_x+=x_pixel, sum_y+=y_pixel, update running min/max. Pixels with de=0 have no effect.
- Frame end = de=1 and x_pixel=H_ACT-1 and y_pixel=V_ACT-1; that pixel is included.
- On frame end in IDLE: snapshot count/sums/bbox (including the last pixel) into divider registers, clear accumulators (min regs to all-ones, max/count/sums to 0), go DIV_X.
- FSM: IDLE -> DIV_X (SUM_W cycles, sum_x/count) -> DIV_Y (SUM_W cycles, sum_y/count) -> PUBLISH (1 cycle) -> IDLE.
- PUBLISH: result_valid=1; pix_count always updated; if count >= MIN_PIXELS: found=1, cx, cy and bbox updated; else found=0, cx/cy/bbox hold previous values.
- Divider always runs full length (fixed latency); divide-by-zero quotient is never published because count=0 < MIN_PIXELS (MIN_PIXELS >= 1 required).
- Frame end while not IDLE: that frame's snapshot is discarded, accumulators still cleared, overrun pulses one cycle later; in-flight division continues unaffected.
- Accumulation of the next frame proceeds in parallel with division.
- Width rules: all sums unsigned, no saturation needed given parameter bounds; quotient truncated to COORD_W.

## Timing

- Reset: all outputs 0, state IDLE, accumulators cleared (min regs all-ones). Reset mid-division abandons it; no result_valid for that frame.
- Frame-end pixel sampled at edge T; DIV_X occupies T+1..T+SUM_W; DIV_Y T+SUM_W+1..T+2*SUM_W; result_valid high in cycle T+2*SUM_W+1 with new outputs visible in the same cycle (registered). Default: 51 cycles.
- Outputs stable between result_valid pulses.
- Required: frame period > 2*SUM_W+2 cycles, always true with blanking.

## Structure

- Package vision_pkg: H_ACT, V_ACT, COORD_W, CNT_W, SUM_W defaults, FSM state enum (IDLE, DIV_X, DIV_Y, PUBLISH).
- Sub-module seq_divider: restoring unsigned divider, SUM_W-bit dividend, CNT_W-bit divisor, start pulse, SUM_W-cycle run, done pulse; instantiated once and reused for x then y.

## Test plan

- 10x10 green square at x 100..109, y 50..59, rest 0 -> result_valid 51 cycles after frame end; found=1, pix_count=100, cx=104, cy=54, bbox (100,109,50,59).
- 63 green pixels in a 9x7 block after a valid frame -> found=0, pix_count=63, cx/cy/bbox equal previous frame values.
- Empty frame -> pix_count=0, found=0, single result_valid, no X on outputs.
- g_detect=1 with de=0 throughout blanking plus one frame of de-qualified green at (0,0) only -> pix_count=1, no blanking contribution.
- Short synthetic frame ending 20 cycles after the previous frame end -> overrun pulse, first result published correctly at 51 cycles, second frame dropped.
- reset_n low for 1 cycle at 10 cycles into DIV_X -> all outputs 0, no result_valid; next full frame produces correct result.
